wb_arb_ctrl: RTL and testbench
==============================

// Module: wb_arb_ctrl
// PURPOSE
//  Arbitration controller sharing one Wishbone slave port among N_MASTERS requesters.
//  Issues a registered one-hot grant plus id that the interconnect mux consumes.
//  Holds the grant for the whole CYC, with round-robin fairness across requesters.
//  Optionally aborts a hung transfer with a watchdog ERR, so a dead slave cannot lock the bus.
// PARAMETERS
//  N_MASTERS      3    number of requesters, 2..8
//  TMO_CYCLES     256  watchdog limit: STB-high cycles with no ACK/ERR, >=2
//  TMO_CNT_W      9    counter width, >= $clog2(TMO_CYCLES+1)
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous reset, active-high
//  m_cyc      in   N_MASTERS    CYC of each master
//  m_stb      in   N_MASTERS    STB of each master
//  s_ack      in   1            ACK from the shared slave
//  s_err      in   1            ERR from the shared slave
//  gnt        out  N_MASTERS    one-hot grant, registered
//  gnt_valid  out  1            |gnt
//  gnt_id     out  ID_W         index of granted master; ID_W=$clog2(N_MASTERS)
//  s_stb_mask out  1            1 = interconnect forces slave STB/CYC low
//  tmo_err    out  N_MASTERS    one-cycle ERR pulse, ORed into the master ERR
// BEHAVIOUR
//  Reset values: state=IDLE; gnt=0, gnt_valid=0, gnt_id=0, s_stb_mask=0, tmo_err=0;
//   last_id=N_MASTERS-1, so master 0 wins first; tmo_cnt=0.
//  Reset asserted mid-transfer drops the grant at the next edge; no ERR is generated.
//  IDLE
//   - If |m_cyc: pick the first requester at or after (last_id+1) mod N_MASTERS, searching upward with wrap.
//   - Register gnt/gnt_id, set last_id to the winner, go to GRANT.
//   - Latency: CYC sampled at edge k -> gnt visible after edge k, so the master sees it one cycle later.
//  GRANT
//   - Holds while m_cyc[gnt_id]=1; ACK/ERR pass through, multiple beats per CYC allowed.
//   - When m_cyc[gnt_id]=0: clear gnt and go to IDLE.
//   - One mandatory idle cycle between grants: no back-to-back re-grant on the same edge.
//  Requests from other masters while granted are ignored. No preemption mid-CYC.
//  A master dropping CYC in the same cycle as its ACK is legal and releases normally.
//  Simultaneous requests: the round-robin order decides; last_id changes only on a grant.
//  gnt is never X and never multi-hot; gnt_id==0 whenever gnt==0.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//   - In GRANT, tmo_cnt increments each cycle m_stb[gnt_id]&~s_ack&~s_err.
//   - tmo_cnt clears on ACK, ERR or STB low; it saturates and never wraps.
//   - When tmo_cnt reaches TMO_CYCLES-1 with the condition still true, go to TMO.
//   - TMO: tmo_err[gnt_id]=1 for exactly one cycle.
//   - TMO: s_stb_mask=1 from TMO entry until IDLE, so the slave sees CYC/STB low.
//   - Stay in TMO with the grant held until m_cyc[gnt_id]=0, then go to IDLE.
//   - A slave ACK arriving in the TMO-entry cycle is ignored, because the mask is already applied.
//  WB_ARB_TIMEOUT_EN undefined: no counter or TMO state; tmo_err=0 and s_stb_mask=0 constantly.
// STRUCTURE
//  wb_arb_pkg holds:
//   - typedef enum logic[1:0] {ARB_IDLE, ARB_GRANT, ARB_TMO} wb_arb_state_e
//   - function onehot2id()
//   - localparam WB_ARB_MAX_MASTERS=8
//  One sub-module, wb_arb_rr_pick (combinational):
//   - inputs req[N], last_id; outputs pick_oh[N], pick_id, pick_valid
//   - implemented with double-width masked priority encode
//  wb_arb_ctrl holds the FSM, the grant registers and the watchdog.
// TESTING
//  T1: rst=1 for 3 clk; release; m_cyc=3'b111 -> gnt=001; master 0 drops CYC -> IDLE,
//      then gnt=010, then 100, then 001 (rotation).
//  T2: m0 holds CYC for 5 beats with s_ack each cycle while m1 requests
//      -> gnt stays 001 throughout; gnt=010 two edges after m0 CYC falls.
//  T3: only m2 requests repeatedly -> each grant gnt_id=2; one idle cycle between grants.
//  T4 (WB_ARB_TIMEOUT_EN, TMO_CYCLES=4): m1 STB held, no ACK
//      -> tmo_err=010 for one cycle 4 cycles after grant; s_stb_mask=1 until m1 drops CYC.
//  T5: ACK on cycle 3 of a 4-cycle watchdog -> tmo_cnt clears, no tmo_err.
//      Without the macro, the T4 stimulus -> tmo_err stays 0 and gnt is held.
//  T6: assert rst while gnt=100 mid-transfer -> next edge gnt=0, tmo_err=0, next grant goes to m0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone arbitration controller.
package wb_arb_pkg;

  localparam int unsigned WB_ARB_MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_TMO
  } wb_arb_state_e;

  // Index of the set bit; callers guarantee at most one bit is set.
  function automatic int unsigned onehot2id(input logic [WB_ARB_MAX_MASTERS-1:0] oh);
    int unsigned id;
    id = 0;
    for (int unsigned i = 0; i < WB_ARB_MAX_MASTERS; i++) begin
      if (oh[i]) id = i;
    end
    return id;
  endfunction

endpackage

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_id, with wrap.
module wb_arb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 3,
  parameter int unsigned ID_W      = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req_i,
  input  logic [ID_W-1:0]      last_id_i,
  output logic [N_MASTERS-1:0] pick_oh_o,
  output logic [ID_W-1:0]      pick_id_o,
  output logic                 pick_valid_o
);

  localparam int N = int'(N_MASTERS);

  logic [2*N_MASTERS-1:0]        dbl;
  logic [WB_ARB_MAX_MASTERS-1:0] oh_pad;

  // Duplicated request vector; the window (last_id, last_id+N] covers each master once.
  always_comb begin
    dbl          = {req_i, req_i};
    pick_oh_o    = '0;
    pick_valid_o = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!pick_valid_o && dbl[i] && (i > int'(last_id_i)) && (i <= int'(last_id_i) + N)) begin
        pick_valid_o       = 1'b1;
        pick_oh_o[i % N]   = 1'b1;
      end
    end
  end

  always_comb begin
    oh_pad                = '0;
    oh_pad[N_MASTERS-1:0] = pick_oh_o;
    pick_id_o             = ID_W'(onehot2id(oh_pad));
  end

endmodule

// File: rtl/wb_arb_ctrl.sv
// Round-robin Wishbone arbiter holding the grant for a whole CYC.
// Optional watchdog ERR on hung transfers is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arb_ctrl
  import wb_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS  = 3,
  parameter int unsigned TMO_CYCLES = 256,
  parameter int unsigned TMO_CNT_W  = 9,
  parameter int unsigned ID_W       = $clog2(N_MASTERS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_MASTERS-1:0] m_cyc_i,
  input  logic [N_MASTERS-1:0] m_stb_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic                 gnt_valid_o,
  output logic [ID_W-1:0]      gnt_id_o,
  output logic                 s_stb_mask_o,
  output logic [N_MASTERS-1:0] tmo_err_o
);

  wb_arb_state_e          state_q, state_d;
  logic [N_MASTERS-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]        gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]        last_id_q, last_id_d;
  logic [N_MASTERS-1:0]   pick_oh;
  logic [ID_W-1:0]        pick_id;
  logic                   pick_valid;

  wb_arb_rr_pick #(
    .N_MASTERS (N_MASTERS),
    .ID_W      (ID_W)
  ) u_pick (
    .req_i        (m_cyc_i),
    .last_id_i    (last_id_q),
    .pick_oh_o    (pick_oh),
    .pick_id_o    (pick_id),
    .pick_valid_o (pick_valid)
  );

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [TMO_CNT_W-1:0] TmoLast = TMO_CNT_W'(TMO_CYCLES - 1);

  logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [N_MASTERS-1:0] tmo_err_q, tmo_err_d;
  logic                 mask_q, mask_d;
  logic                 stall;

  assign stall = m_stb_i[gnt_id_q] & ~s_ack_i & ~s_err_i;
`else
  logic unused_wdog;
  assign unused_wdog = ^{m_stb_i, s_ack_i, s_err_i};
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
`ifdef WB_ARB_TIMEOUT_EN
    tmo_cnt_d = '0;
    tmo_err_d = '0;
    mask_d    = mask_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          gnt_d     = pick_oh;
          gnt_id_d  = pick_id;
          last_id_d = pick_id;
          state_d   = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!m_cyc_i[gnt_id_q]) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          state_d  = ARB_IDLE;
`ifdef WB_ARB_TIMEOUT_EN
        end else if (stall) begin
          if (tmo_cnt_q == TmoLast) begin
            tmo_err_d = gnt_q;
            mask_d    = 1'b1;
            state_d   = ARB_TMO;
          end else if (tmo_cnt_q != '1) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q;
          end
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      // Slave is masked off here, so ACK/ERR are deliberately ignored.
      ARB_TMO: begin
        if (!m_cyc_i[gnt_id_q]) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          mask_d   = 1'b0;
          state_d  = ARB_IDLE;
        end
      end
`endif
      default: begin
        gnt_d    = '0;
        gnt_id_d = '0;
        state_d  = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      last_id_q <= ID_W'(N_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
      tmo_cnt_q <= '0;
      tmo_err_q <= '0;
      mask_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
`ifdef WB_ARB_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
      mask_q    <= mask_d;
`endif
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = |gnt_q;
  assign gnt_id_o    = gnt_id_q;
`ifdef WB_ARB_TIMEOUT_EN
  assign s_stb_mask_o = mask_q;
  assign tmo_err_o    = tmo_err_q;
`else
  assign s_stb_mask_o = 1'b0;
  assign tmo_err_o    = '0;
`endif

endmodule

// File: tb/tb_wb_arb_ctrl.sv
// Directed self-checking bench for wb_arb_ctrl (3 masters, 4-cycle watchdog when enabled).
module tb_wb_arb_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] m_cyc;
  logic [2:0] m_stb;
  logic       s_ack;
  logic       s_err;
  logic [2:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       s_stb_mask;
  logic [2:0] tmo_err;

  int n_assert = 0;
  int n_fail   = 0;

  wb_arb_ctrl #(
    .N_MASTERS  (3),
    .TMO_CYCLES (4),
    .TMO_CNT_W  (3)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .m_cyc_i      (m_cyc),
    .m_stb_i      (m_stb),
    .s_ack_i      (s_ack),
    .s_err_i      (s_err),
    .gnt_o        (gnt),
    .gnt_valid_o  (gnt_valid),
    .gnt_id_o     (gnt_id),
    .s_stb_mask_o (s_stb_mask),
    .tmo_err_o    (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_gnt(input string tag, input logic [2:0] eg, input logic [1:0] eid);
    check({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check({tag, ".id"}, 32'(gnt_id), 32'(eid));
  endtask

  initial begin
    rst   = 1'b1;
    m_cyc = 3'b000;
    m_stb = 3'b000;
    s_ack = 1'b0;
    s_err = 1'b0;
    repeat (3) step();
    check_gnt("reset", 3'b000, 2'd0);
    check("reset.valid", 32'(gnt_valid), 32'd0);
    check("reset.mask", 32'(s_stb_mask), 32'd0);
    check("reset.tmo", 32'(tmo_err), 32'd0);

    // T1: rotation
    rst   = 1'b0;
    m_cyc = 3'b111;
    step(); check_gnt("t1.g0", 3'b001, 2'd0);
    check("t1.valid", 32'(gnt_valid), 32'd1);
    m_cyc = 3'b110;
    step(); check_gnt("t1.idle0", 3'b000, 2'd0);
    step(); check_gnt("t1.g1", 3'b010, 2'd1);
    m_cyc = 3'b101;
    step(); check_gnt("t1.idle1", 3'b000, 2'd0);
    step(); check_gnt("t1.g2", 3'b100, 2'd2);
    m_cyc = 3'b011;
    step(); check_gnt("t1.idle2", 3'b000, 2'd0);
    step(); check_gnt("t1.g0b", 3'b001, 2'd0);

    // T2: m0 holds for 5 ACKed beats while m1 waits
    s_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); check_gnt("t2.hold", 3'b001, 2'd0);
    end
    s_ack = 1'b0;
    m_cyc = 3'b010;
    step(); check_gnt("t2.rel", 3'b000, 2'd0);
    step(); check_gnt("t2.g1", 3'b010, 2'd1);
    m_cyc = 3'b000;
    step(); check_gnt("t2.idle", 3'b000, 2'd0);

    // T3: only m2 requests repeatedly
    m_cyc = 3'b100;
    step(); check_gnt("t3.g2a", 3'b100, 2'd2);
    step(); check_gnt("t3.hold", 3'b100, 2'd2);
    m_cyc = 3'b000;
    step(); check_gnt("t3.idle", 3'b000, 2'd0);
    m_cyc = 3'b100;
    step(); check_gnt("t3.g2b", 3'b100, 2'd2);
    m_cyc = 3'b000;
    step(); check_gnt("t3.idle2", 3'b000, 2'd0);

`ifdef WB_ARB_TIMEOUT_EN
    // T4: m1 stalls with no ACK -> watchdog fires 4 cycles after grant
    m_cyc = 3'b010;
    m_stb = 3'b010;
    step(); check_gnt("t4.g1", 3'b010, 2'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      check("t4.pre_tmo", 32'(tmo_err), 32'd0);
      check("t4.pre_mask", 32'(s_stb_mask), 32'd0);
    end
    step();
    check("t4.tmo", 32'(tmo_err), 32'b010);
    check("t4.mask", 32'(s_stb_mask), 32'd1);
    s_ack = 1'b1;
    step();
    check("t4.tmo_once", 32'(tmo_err), 32'd0);
    check("t4.mask_hold", 32'(s_stb_mask), 32'd1);
    check_gnt("t4.gnt_hold", 3'b010, 2'd1);
    s_ack = 1'b0;
    step();
    check("t4.mask_hold2", 32'(s_stb_mask), 32'd1);
    m_cyc = 3'b000;
    m_stb = 3'b000;
    step();
    check("t4.mask_clr", 32'(s_stb_mask), 32'd0);
    check_gnt("t4.idle", 3'b000, 2'd0);

    // T5: ACK on the third stall cycle restarts the count
    m_cyc = 3'b010;
    m_stb = 3'b010;
    step(); check_gnt("t5.g1", 3'b010, 2'd1);
    step();
    step();
    s_ack = 1'b1;
    step(); check("t5.ack", 32'(tmo_err), 32'd0);
    s_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5.no_tmo", 32'(tmo_err), 32'd0);
      check("t5.no_mask", 32'(s_stb_mask), 32'd0);
    end
    m_cyc = 3'b000;
    m_stb = 3'b000;
    step(); check_gnt("t5.idle", 3'b000, 2'd0);
    check("t5.tmo_idle", 32'(tmo_err), 32'd0);
`else
    // Watchdog absent: stalled transfer keeps its grant, no ERR, no mask
    m_cyc = 3'b010;
    m_stb = 3'b010;
    step(); check_gnt("t5n.g1", 3'b010, 2'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("t5n.tmo", 32'(tmo_err), 32'd0);
      check("t5n.mask", 32'(s_stb_mask), 32'd0);
      check("t5n.gnt", 32'(gnt), 32'b010);
    end
    m_cyc = 3'b000;
    m_stb = 3'b000;
    step(); check_gnt("t5n.idle", 3'b000, 2'd0);
`endif

    // T6: reset mid-transfer with m2 granted
    m_cyc = 3'b100;
    m_stb = 3'b100;
    step(); check_gnt("t6.g2", 3'b100, 2'd2);
    step();
    rst   = 1'b1;
    m_cyc = 3'b111;
    step();
    check_gnt("t6.rst", 3'b000, 2'd0);
    check("t6.valid", 32'(gnt_valid), 32'd0);
    check("t6.tmo", 32'(tmo_err), 32'd0);
    check("t6.mask", 32'(s_stb_mask), 32'd0);
    rst = 1'b0;
    step(); check_gnt("t6.g0", 3'b001, 2'd0);
    m_cyc = 3'b000;
    m_stb = 3'b000;
    step(); check_gnt("t6.idle", 3'b000, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
